// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the I/D single-port SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

    typedef enum logic [1:0] {
        RSP_IDLE     = 2'd0,
        RSP_INFLIGHT = 2'd1,
        RSP_HOLD     = 2'd2
    } rsp_state_e;

    // Macro byte enables are active-low: all ones masks every lane.
    localparam logic [3:0] SRAM_BEN_NONE = 4'hF;
    localparam logic [3:0] SRAM_BEN_ALL  = 4'h0;

    function automatic logic [3:0] write_ben(input logic [3:0] be_active_high);
        return ~be_active_high;
    endfunction

endpackage : sram_arb_pkg

`default_nettype wire

// File: rtl/sram_arb_rsp_slot.sv
// ============================================================================
// Module      : sram_arb_rsp_slot
// Description : Per-port response slot: tracks one outstanding SRAM access and
//               parks its read data in a hold register under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_rsp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              grant,
    input  logic              rsp_ready,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              eligible,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
);
    import sram_arb_pkg::*;

    rsp_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RSP_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        eligible  = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            RSP_IDLE: begin
                eligible = req_valid;
                if (grant) state_d = RSP_INFLIGHT;
            end
            RSP_INFLIGHT: begin
                rsp_valid = 1'b1;
                rsp_rdata = sram_dout;
                // Draining this cycle frees the slot for a back-to-back grant.
                eligible  = req_valid && rsp_ready;
                if (rsp_ready) begin
                    state_d = grant ? RSP_INFLIGHT : RSP_IDLE;
                end else begin
                    hold_d  = sram_dout;
                    state_d = RSP_HOLD;
                end
            end
            RSP_HOLD: begin
                rsp_valid = 1'b1;
                rsp_rdata = hold_q;
                if (rsp_ready) state_d = RSP_IDLE;
            end
            default: state_d = RSP_IDLE;
        endcase
    end

endmodule : sram_arb_rsp_slot

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module      : sram_arbiter
// Description : Round-robin sharing of one single-port SRAM macro between the
//               fetch (I) and load/store (D) ports. Optional grant/conflict
//               counters are built when SRAM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_rdata,
    input  logic              i_rsp_ready,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_be,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,
    input  logic              d_rsp_ready,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [3:0]        sram_ben,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_i_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_conflicts
`endif
);
    import sram_arb_pkg::*;

    logic     i_elig, d_elig;
    logic     grant_i, grant_d;
    port_id_e last_grant_q, last_grant_d;

    sram_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot_i (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (i_req_valid),
        .grant     (grant_i),
        .rsp_ready (i_rsp_ready),
        .sram_dout (sram_dout),
        .eligible  (i_elig),
        .rsp_valid (i_rsp_valid),
        .rsp_rdata (i_rsp_rdata)
    );

    sram_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (d_req_valid),
        .grant     (grant_d),
        .rsp_ready (d_rsp_ready),
        .sram_dout (sram_dout),
        .eligible  (d_elig),
        .rsp_valid (d_rsp_valid),
        .rsp_rdata (d_rsp_rdata)
    );

    // Grants are masked by rst_n so the macro sees idle controls throughout reset.
    always_comb begin
        grant_i = rst_n && i_elig && (!d_elig || (last_grant_q == PORT_D));
        grant_d = rst_n && d_elig && (!i_elig || (last_grant_q == PORT_I));
        last_grant_d = last_grant_q;
        if (grant_i)      last_grant_d = PORT_I;
        else if (grant_d) last_grant_d = PORT_D;
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= PORT_D;
        else        last_grant_q <= last_grant_d;
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = SRAM_BEN_NONE;
        sram_addr = '0;
        sram_din  = '0;
        if (grant_i) begin
            sram_cen  = 1'b0;
            sram_addr = i_req_addr;
        end else if (grant_d) begin
            sram_cen  = 1'b0;
            sram_addr = d_req_addr;
            sram_din  = d_req_wdata;
            sram_wen  = ~d_req_we;
            sram_ben  = d_req_we ? write_ben(d_req_be) : SRAM_BEN_ALL;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] stat_i_grants_q, stat_i_grants_d;
    logic [31:0] stat_d_grants_q, stat_d_grants_d;
    logic [31:0] stat_conflicts_q, stat_conflicts_d;

    always_comb begin
        stat_i_grants_d  = stat_i_grants_q  + {31'd0, grant_i};
        stat_d_grants_d  = stat_d_grants_q  + {31'd0, grant_d};
        stat_conflicts_d = stat_conflicts_q + {31'd0, (i_elig && d_elig)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_i_grants_q  <= '0;
            stat_d_grants_q  <= '0;
            stat_conflicts_q <= '0;
        end else begin
            stat_i_grants_q  <= stat_i_grants_d;
            stat_d_grants_q  <= stat_d_grants_d;
            stat_conflicts_q <= stat_conflicts_d;
        end
    end

    assign stat_i_grants  = stat_i_grants_q;
    assign stat_d_grants  = stat_d_grants_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule : sram_arbiter

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter with an SRAM macro model
//               and a queue-based reference of grants and responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0, i_req_ready;
    logic [31:0] i_req_addr = '0;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic        i_rsp_ready = 1'b0;
    logic        d_req_valid = 1'b0, d_req_ready;
    logic [31:0] d_req_addr = '0;
    logic        d_req_we = 1'b0;
    logic [3:0]  d_req_be = '0;
    logic [31:0] d_req_wdata = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_ready = 1'b0;
    logic        sram_cen, sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr, sram_din;
    logic [31:0] sram_dout;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0] stat_i_grants, stat_d_grants, stat_conflicts;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_ready(i_rsp_ready),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_ready(d_rsp_ready),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
`ifdef SRAM_ARB_STATS_EN
        , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        if (k == 16) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(k) * 32'h0001_0203;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom_range(0, 63)), 2'b00};
    endfunction

    // SRAM macro model: registered read, read-before-write, active-low controls.
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = init_word(k);
        sram_dout = '0;
    end

    always @(posedge clk) begin
        if (!sram_cen) begin
            sram_dout <= mem[sram_addr[9:2]];
            if (!sram_wen)
                mem[sram_addr[9:2]] <= merge_be(mem[sram_addr[9:2]], sram_din, ~sram_ben);
        end
    end

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_be = '0; d_req_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h44;
        d_req_valid = 1'b1; d_req_addr = 32'h48;
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (i_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_i_rsp_valid got=%b exp=0", i_rsp_valid); end
        checks++; if (d_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_d_rsp_valid got=%b exp=0", d_rsp_valid); end
        checks++; if ({i_req_ready, d_req_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {i_req_ready, d_req_ready}); end
        checks++; if ({sram_cen, sram_wen, sram_ben} !== 6'b11_1111) begin failures++; $display("FAIL reset_sram_ctl got=%b exp=111111", {sram_cen, sram_wen, sram_ben}); end
        checks++; if ({sram_addr, sram_din} !== 64'd0) begin failures++; $display("FAIL reset_sram_addr_din got=%h exp=0", {sram_addr, sram_din}); end
`ifdef SRAM_ARB_STATS_EN
        checks++; if ({stat_i_grants, stat_d_grants, stat_conflicts} !== 96'd0) begin failures++; $display("FAIL reset_stats got=%h exp=0", {stat_i_grants, stat_d_grants, stat_conflicts}); end
`endif
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h40; i_rsp_ready = 1'b1;
        #1;
        checks++; if (i_req_ready !== 1'b1) begin failures++; $display("FAIL single_grant got=%b exp=1", i_req_ready); end
        checks++; if ({sram_cen, sram_wen, sram_ben} !== 6'b01_1111) begin failures++; $display("FAIL single_sram_ctl got=%b exp=011111", {sram_cen, sram_wen, sram_ben}); end
        checks++; if (sram_addr !== 32'h40) begin failures++; $display("FAIL single_addr got=%h exp=40", sram_addr); end
        @(negedge clk);
        i_req_valid = 1'b0;
        #1;
        checks++; if (i_rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", i_rsp_valid); end
        checks++; if (i_rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rsp_data got=%h exp=deadbeef", i_rsp_rdata); end
        checks++; if (sram_cen !== 1'b1) begin failures++; $display("FAIL single_idle_cen got=%b exp=1", sram_cen); end
        @(negedge clk); #1;
        checks++; if (i_rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_done got=%b exp=0", i_rsp_valid); end
    endtask

    task automatic test_write_be();
        logic [31:0] old_w, new_w;
        old_w = ref_mem[2];
        new_w = {old_w[31:24], 8'h22, old_w[15:8], 8'h44};
        d_rsp_ready = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b1; d_req_addr = 32'h8; d_req_we = 1'b1; d_req_be = 4'b0101;
        d_req_wdata = 32'h11223344;
        #1;
        checks++; if (d_req_ready !== 1'b1) begin failures++; $display("FAIL wr_grant got=%b exp=1", d_req_ready); end
        checks++; if ({sram_cen, sram_wen, sram_ben} !== 6'b00_1010) begin failures++; $display("FAIL wr_sram_ctl got=%b exp=001010", {sram_cen, sram_wen, sram_ben}); end
        checks++; if ({sram_addr, sram_din} !== {32'h8, 32'h11223344}) begin failures++; $display("FAIL wr_addr_din got=%h exp=%h", {sram_addr, sram_din}, {32'h8, 32'h11223344}); end
        ref_mem[2] = new_w;
        @(negedge clk);
        d_req_we = 1'b0; d_req_be = 4'h0;
        #1;
        checks++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== old_w) begin failures++; $display("FAIL wr_rsp_old got=%b/%h exp=1/%h", d_rsp_valid, d_rsp_rdata, old_w); end
        checks++; if ({d_req_ready, sram_cen, sram_wen, sram_ben} !== 7'b1_01_0000) begin failures++; $display("FAIL rd_b2b_ctl got=%b exp=1010000", {d_req_ready, sram_cen, sram_wen, sram_ben}); end
        @(negedge clk);
        d_req_we = 1'b1; d_req_be = 4'h0; d_req_wdata = $urandom;
        #1;
        checks++; if (d_rsp_rdata !== new_w) begin failures++; $display("FAIL wr_readback got=%h exp=%h", d_rsp_rdata, new_w); end
        checks++; if ({d_req_ready, sram_cen, sram_wen, sram_ben} !== 7'b1_00_1111) begin failures++; $display("FAIL wr_be0_ctl got=%b exp=1001111", {d_req_ready, sram_cen, sram_wen, sram_ben}); end
        @(negedge clk);
        d_req_we = 1'b0;
        #1;
        checks++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== new_w) begin failures++; $display("FAIL wr_be0_rsp got=%b/%h exp=1/%h", d_rsp_valid, d_rsp_rdata, new_w); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (d_rsp_rdata !== new_w) begin failures++; $display("FAIL wr_be0_unchanged got=%h exp=%h", d_rsp_rdata, new_w); end
    endtask

    task automatic test_conflict();
        logic [31:0] ia, da, prev_a;
        do_reset();
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        ia = rnd_addr(); da = rnd_addr(); prev_a = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            i_req_valid = 1'b1; i_req_addr = ia;
            d_req_valid = 1'b1; d_req_addr = da; d_req_we = 1'b0;
            #1;
            checks++;
            if ({i_req_ready, d_req_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL conflict_grant_%0d got=%b exp=%b", k, {i_req_ready, d_req_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (k > 0) begin
                checks++;
                if ((k % 2 == 1) ? (i_rsp_rdata !== ref_mem[prev_a[9:2]] || !i_rsp_valid)
                                 : (d_rsp_rdata !== ref_mem[prev_a[9:2]] || !d_rsp_valid)) begin
                    failures++; $display("FAIL conflict_rsp_%0d got_i=%h got_d=%h exp=%h", k, i_rsp_rdata, d_rsp_rdata, ref_mem[prev_a[9:2]]);
                end
            end
            if (k % 2 == 0) begin prev_a = ia; ia = rnd_addr(); end
            else            begin prev_a = da; da = rnd_addr(); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (!d_rsp_valid || d_rsp_rdata !== ref_mem[prev_a[9:2]]) begin failures++; $display("FAIL conflict_last_rsp got=%h exp=%h", d_rsp_rdata, ref_mem[prev_a[9:2]]); end
`ifdef SRAM_ARB_STATS_EN
        checks++; if (stat_conflicts !== 32'd6) begin failures++; $display("FAIL stat_conflicts got=%0d exp=6", stat_conflicts); end
        checks++; if (stat_i_grants !== 32'd3 || stat_d_grants !== 32'd3) begin failures++; $display("FAIL stat_grants got=%0d/%0d exp=3/3", stat_i_grants, stat_d_grants); end
`endif
    endtask

    task automatic test_hold();
        logic [31:0] a_i, b_i;
        logic [31:0] da [0:4];
        do_reset();
        a_i = rnd_addr(); b_i = rnd_addr();
        for (int k = 0; k < 5; k++) da[k] = rnd_addr();
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = a_i; i_rsp_ready = 1'b0;
        d_req_valid = 1'b1; d_req_addr = da[0]; d_req_we = 1'b0; d_rsp_ready = 1'b1;
        #1;
        checks++; if ({i_req_ready, d_req_ready} !== 2'b10) begin failures++; $display("FAIL hold_first_grant got=%b exp=10", {i_req_ready, d_req_ready}); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            i_req_addr = b_i;
            if (k >= 2) d_req_addr = da[k-1];
            i_rsp_ready = (k == 4);
            #1;
            checks++;
            if (!i_rsp_valid || i_rsp_rdata !== ref_mem[a_i[9:2]] || i_req_ready || !d_req_ready) begin
                failures++; $display("FAIL hold_cycle_%0d got=%b/%h/%b%b exp=1/%h/01", k, i_rsp_valid, i_rsp_rdata, i_req_ready, d_req_ready, ref_mem[a_i[9:2]]);
            end
            if (k >= 2) begin
                checks++;
                if (!d_rsp_valid || d_rsp_rdata !== ref_mem[da[k-2][9:2]]) begin
                    failures++; $display("FAIL hold_d_stream_%0d got=%h exp=%h", k, d_rsp_rdata, ref_mem[da[k-2][9:2]]);
                end
            end
        end
        @(negedge clk);
        d_req_addr = da[4];
        #1;
        checks++; if (i_rsp_valid !== 1'b0 || {i_req_ready, d_req_ready} !== 2'b10) begin failures++; $display("FAIL hold_release got=%b/%b exp=0/10", i_rsp_valid, {i_req_ready, d_req_ready}); end
        checks++; if (d_rsp_rdata !== ref_mem[da[3][9:2]]) begin failures++; $display("FAIL hold_d_last got=%h exp=%h", d_rsp_rdata, ref_mem[da[3][9:2]]); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (!i_rsp_valid || i_rsp_rdata !== ref_mem[b_i[9:2]]) begin failures++; $display("FAIL hold_second_rsp got=%h exp=%h", i_rsp_rdata, ref_mem[b_i[9:2]]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_req_valid = (k < 3);
            i_req_addr  = (k < 3) ? 32'(4 * k) : 32'h0;
            #1;
            checks++;
            if (i_req_ready !== (k < 3)) begin failures++; $display("FAIL b2b_grant_%0d got=%b exp=%b", k, i_req_ready, (k < 3)); end
            if (k >= 1 && k <= 3) begin
                checks++;
                if (!i_rsp_valid || i_rsp_rdata !== ref_mem[k-1]) begin failures++; $display("FAIL b2b_rsp_%0d got=%b/%h exp=1/%h", k, i_rsp_valid, i_rsp_rdata, ref_mem[k-1]); end
            end
        end
        checks++; if (i_rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", i_rsp_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        d_req_valid = 1'b1; d_req_addr = rnd_addr(); d_req_we = 1'b0; d_rsp_ready = 1'b1;
        #1;
        checks++; if (d_req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_grant got=%b exp=1", d_req_ready); end
        @(negedge clk);
        rst_n = 1'b0;
        i_req_valid = 1'b1; i_req_addr = rnd_addr();
        #1;
        checks++; if (d_rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rsp got=%b exp=0", d_rsp_valid); end
        checks++; if ({sram_cen, sram_wen, sram_ben, i_req_ready, d_req_ready} !== 8'b11_1111_00) begin failures++; $display("FAIL rstmid_sram got=%b exp=11111100", {sram_cen, sram_wen, sram_ben, i_req_ready, d_req_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if ({i_req_ready, d_req_ready} !== 2'b10) begin failures++; $display("FAIL rstmid_conflict got=%b exp=10", {i_req_ready, d_req_ready}); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    // Random traffic against a queue model: expected grants come from the
    // eligibility and alternation rules, expected data from ref_mem.
    task automatic test_random();
        logic [31:0] iq[$];
        logic [31:0] dq[$];
        bit i_pend, d_pend, i_held, d_held, last_d, e_i, e_d, x_gi, x_gd;
        int exp_ig, exp_dg, exp_conf;
        logic [31:0] old_w;
        do_reset();
        i_pend = 0; d_pend = 0; i_held = 0; d_held = 0; last_d = 1;
        exp_ig = 0; exp_dg = 0; exp_conf = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!i_pend) begin
                i_req_valid = 1'b0;
                if ($urandom_range(0, 2) != 0) begin
                    i_pend = 1; i_req_valid = 1'b1; i_req_addr = rnd_addr();
                end
            end
            if (!d_pend) begin
                d_req_valid = 1'b0;
                if ($urandom_range(0, 2) != 0) begin
                    d_pend = 1; d_req_valid = 1'b1; d_req_addr = rnd_addr();
                    d_req_we = 1'($urandom_range(0, 1)); d_req_be = 4'($urandom);
                    d_req_wdata = $urandom;
                end
            end
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            d_rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_i  = i_pend && (iq.size() == 0 || (!i_held && i_rsp_ready));
            e_d  = d_pend && (dq.size() == 0 || (!d_held && d_rsp_ready));
            x_gi = e_i && (!e_d || last_d);
            x_gd = e_d && (!e_i || !last_d);
            if (e_i && e_d) exp_conf++;
            checks++;
            if ({i_rsp_valid, d_rsp_valid} !== {iq.size() != 0, dq.size() != 0}) begin
                failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, {i_rsp_valid, d_rsp_valid}, {iq.size() != 0, dq.size() != 0});
            end
            checks++;
            if ({i_req_ready, d_req_ready} !== {x_gi, x_gd}) begin
                failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, {i_req_ready, d_req_ready}, {x_gi, x_gd});
            end
            if (iq.size() != 0) begin
                checks++;
                if (i_rsp_rdata !== iq[0]) begin failures++; $display("FAIL rnd_i_data cyc=%0d got=%h exp=%h", cyc, i_rsp_rdata, iq[0]); end
            end
            if (dq.size() != 0) begin
                checks++;
                if (d_rsp_rdata !== dq[0]) begin failures++; $display("FAIL rnd_d_data cyc=%0d got=%h exp=%h", cyc, d_rsp_rdata, dq[0]); end
            end
            i_held = (iq.size() != 0) && !i_rsp_ready;
            d_held = (dq.size() != 0) && !d_rsp_ready;
            if (iq.size() != 0 && i_rsp_ready) void'(iq.pop_front());
            if (dq.size() != 0 && d_rsp_ready) void'(dq.pop_front());
            checks++;
            if (x_gi) begin
                if ({sram_cen, sram_wen, sram_ben} !== 6'b01_1111 || sram_addr !== i_req_addr) begin
                    failures++; $display("FAIL rnd_i_sram cyc=%0d got=%b/%h exp=011111/%h", cyc, {sram_cen, sram_wen, sram_ben}, sram_addr, i_req_addr);
                end
                iq.push_back(ref_mem[i_req_addr[9:2]]);
                i_pend = 0; last_d = 0; exp_ig++;
            end else if (x_gd) begin
                if ({sram_cen, sram_wen, sram_ben} !== {1'b0, ~d_req_we, (d_req_we ? ~d_req_be : 4'h0)} ||
                    sram_addr !== d_req_addr || sram_din !== d_req_wdata) begin
                    failures++; $display("FAIL rnd_d_sram cyc=%0d got=%b/%h/%h", cyc, {sram_cen, sram_wen, sram_ben}, sram_addr, sram_din);
                end
                old_w = ref_mem[d_req_addr[9:2]];
                dq.push_back(old_w);
                if (d_req_we) ref_mem[d_req_addr[9:2]] = merge_be(old_w, d_req_wdata, d_req_be);
                d_pend = 0; last_d = 1; exp_dg++;
            end else begin
                if (sram_cen !== 1'b1) begin failures++; $display("FAIL rnd_idle_cen cyc=%0d got=%b exp=1", cyc, sram_cen); end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
`ifdef SRAM_ARB_STATS_EN
        checks++;
        if (stat_i_grants !== 32'(exp_ig) || stat_d_grants !== 32'(exp_dg) || stat_conflicts !== 32'(exp_conf)) begin
            failures++; $display("FAIL rnd_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_i_grants, stat_d_grants, stat_conflicts, exp_ig, exp_dg, exp_conf);
        end
`else
        checks++;
        if (exp_ig == 0 || exp_dg == 0) begin failures++; $display("FAIL rnd_coverage got=%0d/%0d exp=nonzero", exp_ig, exp_dg); end
`endif
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        test_reset();
        test_single_read();
        test_write_be();
        test_conflict();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sram_arbiter

`default_nettype wire
